// File: rtl/uart_byte_assembler.sv
// uart_byte_assembler
//   Collects LSB-first bit pulses from the UART bit receiver into bytes and
//   buffers them in a show-ahead FIFO with a valid/ready output. A partial
//   byte is discarded if no bit arrives for 2*BIT_CYC cycles, which lets the
//   framing recover after lost bits.
//   Optional feature macro: JPEG_UNSTUFF_EN
//     defined   -> JPEG 0xFF00 byte stuffing is removed and marker codes
//                  (0xFF followed by a non-0x00, non-0xFF byte) are flagged
//                  on out_marker.
//     undefined -> every byte passes unchanged and out_marker is 0.
module uart_byte_assembler #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int FIFO_AW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_bit,
  input  logic               in_valid,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_marker,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic               frame_err
);

  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int TO_CYC  = 2 * BIT_CYC;
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef JPEG_UNSTUFF_EN
  localparam int ENT_W   = 9;
`else
  localparam int ENT_W   = 8;
`endif

  // Bit assembly and inter-bit timeout state
  logic [7:0]       r_sh;
  logic [2:0]       r_bit_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_frame_err;

  // Completed byte is the incoming bit on top of the 7 bits already shifted in
  logic [7:0]       w_byte;
  logic             w_byte_done;
  logic             w_push_req;
  logic [ENT_W-1:0] w_wr_ent;

  assign w_byte      = {in_bit, r_sh[7:1]};
  assign w_byte_done = in_valid && (r_bit_cnt == 3'd7);

  // Shift bits in LSB first; drop a stalled partial byte after the timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh        <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (in_valid) begin
        r_sh      <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;  // 7 -> 0 wrap closes the byte
        r_to_cnt  <= '0;
      end else if (r_bit_cnt != 3'd0) begin
        if (r_to_cnt == TO_W'(TO_CYC - 1)) begin
          r_bit_cnt   <= 3'd0;
          r_sh        <= 8'h00;
          r_to_cnt    <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

`ifdef JPEG_UNSTUFF_EN
  localparam logic [0:0] NORM   = 1'b0;
  localparam logic [0:0] SAW_FF = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       w_marker;

  // Decide per completed byte whether it is stuffing, data or a marker code
  always_comb begin
    w_push_req  = 1'b0;
    w_marker    = 1'b0;
    w_state_nxt = r_state;
    if (w_byte_done) begin
      case (r_state)
        NORM: begin
          w_push_req = 1'b1;
          if (w_byte == 8'hFF) w_state_nxt = SAW_FF;
        end
        SAW_FF: begin
          if (w_byte == 8'h00) begin
            w_state_nxt = NORM;          // stuffed zero is swallowed
          end else if (w_byte == 8'hFF) begin
            w_push_req  = 1'b1;          // fill byte, still after an FF
          end else begin
            w_push_req  = 1'b1;
            w_marker    = 1'b1;
            w_state_nxt = NORM;
          end
        end
        default: w_state_nxt = NORM;
      endcase
    end
  end

  // Unstuffing state advances on every completed byte, even one that is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= NORM;
    else     r_state <= w_state_nxt;
  end

  assign w_wr_ent = {w_marker, w_byte};
`else
  assign w_push_req = w_byte_done;
  assign w_wr_ent   = w_byte;
`endif

  // FIFO storage and control
  logic [ENT_W-1:0]   r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENT_W-1:0]   w_head;

  assign w_full  = (r_count == (FIFO_AW + 1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  // Storage array is data only and needs no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_ent;
  end

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new drop wins over a clear in the same cycle
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  // Head entry is gated by valid so outputs read 0 straight out of reset
  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = !w_empty;
  assign out_data   = out_valid ? w_head[7:0] : 8'h00;
`ifdef JPEG_UNSTUFF_EN
  assign out_marker = out_valid & w_head[8];
`else
  assign out_marker = 1'b0;
`endif
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_byte_assembler.sv
// Testbench for uart_byte_assembler: directed scenarios plus a randomized
// stream, checked by a scoreboard queue filled from a reference model and
// drained by an independent monitor.
module tb_uart_byte_assembler;

  localparam int FIFO_AW = 4;
  localparam int BIT_CYC = 100_000_000 / 115_200;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_bit;
  logic             in_valid;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_marker;
  logic [FIFO_AW:0] fifo_count;
  logic             overflow;
  logic             ovf_clr;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  bit rand_rdy = 1'b0;

  logic [8:0] exp_q[$];
`ifdef JPEG_UNSTUFF_EN
  bit m_ff = 1'b0;  // model: previous kept-or-dropped byte was an unresolved 0xFF
`endif

  uart_byte_assembler #(
    .CLK_FREQ (100_000_000),
    .BAUD_RATE(115_200),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_marker(out_marker),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output beat is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h, required no output", {out_marker, out_data});
      end else begin
        check("pop_data", 32'({out_marker, out_data}), 32'(exp_q.pop_front()));
      end
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  // Reference model: stuffing rules applied to whole bytes
  task automatic model_byte(input logic [7:0] b, input bit drop);
    bit keep;
    bit mk;
    keep = 1'b1;
    mk   = 1'b0;
`ifdef JPEG_UNSTUFF_EN
    if (!m_ff) begin
      if (b == 8'hFF) m_ff = 1'b1;
    end else if (b == 8'h00) begin
      keep = 1'b0;
      m_ff = 1'b0;
    end else if (b != 8'hFF) begin
      mk   = 1'b1;
      m_ff = 1'b0;
    end
`endif
    if (keep && !drop) exp_q.push_back({mk, b});
  endtask

  task automatic send_bit(input logic b);
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    in_bit   = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop, input int gap,
                           input bit rdy_last, input bit clr_last);
    model_byte(b, drop);
    for (int i = 0; i < 7; i++) begin
      send_bit(b[i]);
      if (gap > 0) idle($urandom_range(0, gap));
    end
    if (rdy_last) out_ready = 1'b1;
    if (clr_last) ovf_clr = 1'b1;
    send_bit(b[7]);
    if (rdy_last) out_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_count"}, 32'(fifo_count), 32'h0);
    check({name, "_queue"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int fe0;
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_marker", 32'(out_marker), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);

    // Single byte 0xA5, consumer always ready
    out_ready = 1'b1;
    send_byte(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    check("a5_count1", 32'(fifo_count), 32'h1);
    check("a5_valid1", 32'(out_valid), 32'h1);
    check("a5_data", 32'(out_data), 32'hA5);
    idle(1);
    check("a5_count0", 32'(fifo_count), 32'h0);
    check("a5_valid0", 32'(out_valid), 32'h0);

    // Fill to 16, then two drops (second coincides with ovf_clr)
    out_ready = 1'b0;
    for (int v = 0; v < 16; v++) send_byte(8'(v), 1'b0, 0, 1'b0, 1'b0);
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_ovf0", 32'(overflow), 32'h0);
    send_byte(8'h10, 1'b1, 0, 1'b0, 1'b0);
    check("drop_count", 32'(fifo_count), 32'd16);
    check("drop_ovf", 32'(overflow), 32'h1);
    send_byte(8'h11, 1'b1, 0, 1'b0, 1'b1);
    check("drop_clr_ovf", 32'(overflow), 32'h1);
    out_ready = 1'b1;
    wait_empty("drain16", 100);
    check("ovf_held", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);

    // Timeout after 3 bits, then a clean 0x3C
    fe0 = fe_cnt;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle(2 * BIT_CYC + 10);
    check("ferr_pulses", 32'(fe_cnt - fe0), 32'h1);
    check("ferr_count", 32'(fifo_count), 32'h0);
    send_byte(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    check("after_to_queue", 32'(exp_q.size()), 32'h0);

    // Full FIFO: push and pop on the same edge
    out_ready = 1'b0;
    for (int v = 0; v < 16; v++) send_byte(8'($urandom_range(1, 254)), 1'b0, 0, 1'b0, 1'b0);
    check("full2_count", 32'(fifo_count), 32'd16);
    send_byte(8'h5A, 1'b0, 0, 1'b1, 1'b0);
    check("pushpop_count", 32'(fifo_count), 32'd16);
    check("pushpop_ovf", 32'(overflow), 32'h0);
    out_ready = 1'b1;
    wait_empty("drain_pp", 100);

    // Asynchronous reset mid-byte with bytes queued
    out_ready = 1'b0;
    send_byte(8'($urandom_range(1, 254)), 1'b0, 0, 1'b0, 1'b0);
    send_byte(8'($urandom_range(1, 254)), 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data", 32'(out_data), 32'h0);
    check("arst_count", 32'(fifo_count), 32'h0);
    check("arst_marker", 32'(out_marker), 32'h0);
    check("arst_ferr", 32'(frame_err), 32'h0);
    exp_q.delete();
`ifdef JPEG_UNSTUFF_EN
    m_ff = 1'b0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    b = 8'($urandom_range(1, 254));
    send_byte(b, 1'b0, 0, 1'b0, 1'b0);
    check("arst_next_data", 32'(out_data), 32'(b));
    idle(3);
    check("arst_next_queue", 32'(exp_q.size()), 32'h0);

    // JPEG stuffing stream
    send_byte(8'hFF, 1'b0, 0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 0, 1'b0, 1'b0);
    send_byte(8'hD9, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    check("jpeg_queue", 32'(exp_q.size()), 32'h0);

    // Randomized stream with gaps and a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hFF;
        1:       b = 8'h00;
        2:       b = 8'hD9;
        default: b = 8'($urandom);
      endcase
      send_byte(b, 1'b0, 2, 1'b0, 1'b0);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_empty("rand_drain", 200);
    check("rand_ovf", 32'(overflow), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
